hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard unit between ID and EX. It tracks pending register writes with per-register countdown counters, so any producer latency can be handled, not only single-cycle load-use. It checks NUM_SRC source operands of the instruction in ID, detects branch mispredicts against the PC in ID, and holds a multi-cycle front-end flush. It also exposes saturating stall/mispredict event counters.

## Interface
- DATA_WIDTH, 64, PC/target width
- REG_ID_WIDTH, 5, register id width; register 0 is never tracked
- NUM_SRC, 2, source operands checked per instruction in ID
- MAX_LAT, 4, largest producer latency tracked; counter width CW = $clog2(MAX_LAT+1)
- FLUSH_DEPTH, 2, cycles flush stays asserted after a mispredict (≥1)
- CNT_WIDTH, 32, width of the performance counters
- One clock; reset is synchronous and active-high.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  instruction in ID is valid
- issue_wb  in  1  the ID instruction writes rd
- issue_rd  in  REG_ID_WIDTH  destination of the ID instruction
- issue_lat  in  CW  cycles until its result is forwardable (0 = available next cycle via normal forwarding)
- src_id  in  NUM_SRC×REG_ID_WIDTH  packed source register ids
- src_used  in  NUM_SRC  per-source "operand is read" mask
- branch_valid_ex  in  1  EX holds a resolved control-transfer
- branch_taken_ex  in  1  resolved direction
- target_ex  in  DATA_WIDTH  resolved taken target
- pc_ex  in  DATA_WIDTH  PC of the EX instruction
- pc_id  in  DATA_WIDTH  PC currently in ID
- stall  out  1  hold PC/IF/ID, inject bubble into EX
- mispredict  out  1  redirect this cycle
- redirect_pc  out  DATA_WIDTH  correct next PC (valid when mispredict)
- flush  out  1  squash front-end stages
- stall_events  out  CNT_WIDTH  count of stall cycles, saturating
- mispredict_events  out  CNT_WIDTH  count of mispredicts, saturating

## Operation
- Scoreboard: pend[r] holds CW bits for r in 1..2^REG_ID_WIDTH−1. pend[0] is hard-wired 0.
- Every cycle, nonzero pend[r] decrements by 1.
- An issue occurs when issue_valid && !stall && !flush && !mispredict.
- On an issue with issue_wb && issue_rd≠0, pend[issue_rd] ← min(issue_lat, MAX_LAT). This write overrides that register's decrement in the same cycle.
- RAW: raw = OR over i of (src_used[i] && pend[src_id[i]]≠0).
- WAW: waw = issue_wb && issue_rd≠0 && pend[issue_rd] > issue_lat. This stops a younger short-latency result from being overwritten by an older one.
- Branch resolution: correct = branch_taken_ex ? target_ex : pc_ex+4, computed modulo 2^DATA_WIDTH. The +4 wraps.
- mispredict = branch_valid_ex && (correct ≠ pc_id). redirect_pc = correct; it is 0 when not mispredict.
- Priority order is mispredict > flush > stall. stall = issue_valid && (raw||waw) && !mispredict && !flush.
- Flush: a mispredict loads flush_cnt ← FLUSH_DEPTH. flush = mispredict || flush_cnt≠0. A nonzero flush_cnt decrements each cycle. A mispredict during an active flush reloads flush_cnt to FLUSH_DEPTH.
- Squashed ID instructions never issue, so no scoreboard rollback is needed. Pending writes of older, already-issued instructions keep counting.
- Counters: stall_events increments on each cycle with stall=1. mispredict_events increments on each cycle with mispredict=1. Both saturate at all-ones.

## Timing
- Reset: all pend, flush_cnt and counters are 0. stall, mispredict, flush are 0 and redirect_pc is 0 while reset is held.
- stall, mispredict, redirect_pc and flush are combinational from registered state and current inputs. There is no added latency.
- Scoreboard and counters update at the rising edge of clk.
- A producer with lat=L issued at edge t makes a dependent instruction stall for exactly L cycles after t. L=1 gives the classic one-bubble load-use stall.
- issue_lat above MAX_LAT is clamped. issue_lat=0 leaves pend[rd]=0.
- Reset asserted mid-stall or mid-flush clears everything at that edge. The next cycle has no stall and no flush.

## Structure
- Package hazard_pkg holds default parameter constants and a function for the next-sequential-PC increment (4).
- One sub-module is natural: hazard_sb_counter, a single CW-bit load/decrement-to-zero entry generated per register.
- The flush counter and perf counters stay inline.

## Test plan
- Load-use: issue rd=5 with lat=1, next ID instruction reads src 5 → stall=1 for exactly 1 cycle, then an issue occurs; stall_events=1.
- Long latency: rd=7 lat=3, dependent in the next cycle → stall for 3 cycles. With src_used=0 on that source → no stall.
- x0 and clamp: rd=0 lat=4 → no stall on a reader of x0. rd=9 lat=7 with MAX_LAT=4 → 4 stall cycles.
- WAW: rd=3 lat=3 pending, then rd=3 lat=0 → stall until pend[3]=0.
- Mispredict: taken, target=0x100, pc_id=0x80 → mispredict=1, redirect_pc=0x100, flush high for 1+FLUSH_DEPTH cycles, and stall is suppressed even with a RAW present. Not-taken with pc_ex=0xFFFF_FFFF_FFFF_FFFC, pc_id=0 → no mispredict.
- Simultaneous mispredict with flush_cnt=1 → flush_cnt reloads. Reset mid-flush → flush=0 in the next cycle. Counters preset near all-ones saturate.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared defaults and helpers for the ID/EX hazard scoreboard.
package hazard_pkg;

  localparam int DEF_DATA_WIDTH   = 64;
  localparam int DEF_REG_ID_WIDTH = 5;
  localparam int DEF_NUM_SRC      = 2;
  localparam int DEF_MAX_LAT      = 4;
  localparam int DEF_FLUSH_DEPTH  = 2;
  localparam int DEF_CNT_WIDTH    = 32;

  // Byte distance from a control-transfer to its fall-through instruction.
  function automatic int unsigned seq_pc_inc();
    return 32'd4;
  endfunction

endpackage

// File: rtl/hazard_sb_counter.sv
// One scoreboard entry: cycles remaining until a pending register write is forwardable.
module hazard_sb_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_reg;

  // A new write replaces the countdown of the older one in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID/EX hazard unit: per-register latency scoreboard, branch mispredict detection,
// multi-cycle front-end flush and saturating stall/mispredict event counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int REG_ID_WIDTH = DEF_REG_ID_WIDTH,
  parameter int NUM_SRC      = DEF_NUM_SRC,
  parameter int MAX_LAT      = DEF_MAX_LAT,
  parameter int FLUSH_DEPTH  = DEF_FLUSH_DEPTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  localparam int CW          = $clog2(MAX_LAT + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            issue_valid,
  input  logic                            issue_wb,
  input  logic [REG_ID_WIDTH-1:0]         issue_rd,
  input  logic [CW-1:0]                   issue_lat,
  input  logic [NUM_SRC*REG_ID_WIDTH-1:0] src_id,
  input  logic [NUM_SRC-1:0]              src_used,
  input  logic                            branch_valid_ex,
  input  logic                            branch_taken_ex,
  input  logic [DATA_WIDTH-1:0]           target_ex,
  input  logic [DATA_WIDTH-1:0]           pc_ex,
  input  logic [DATA_WIDTH-1:0]           pc_id,
  output logic                            stall,
  output logic                            mispredict,
  output logic [DATA_WIDTH-1:0]           redirect_pc,
  output logic                            flush,
  output logic [CNT_WIDTH-1:0]            stall_events,
  output logic [CNT_WIDTH-1:0]            mispredict_events
);

  localparam int NREG = 1 << REG_ID_WIDTH;
  localparam int FCW  = $clog2(FLUSH_DEPTH + 1);

  logic [NREG-1:0][CW-1:0] pend;
  logic [CW-1:0]           lat_clamped;
  logic                    issue;
  logic                    wr_en;
  logic                    raw;
  logic                    waw;
  logic [DATA_WIDTH-1:0]   correct_pc;
  logic [FCW-1:0]          flush_cnt_reg;
  logic [CNT_WIDTH-1:0]    stall_events_reg;
  logic [CNT_WIDTH-1:0]    mispredict_events_reg;

  assign lat_clamped = (issue_lat > CW'(MAX_LAT)) ? CW'(MAX_LAT) : issue_lat;
  assign issue       = issue_valid && !stall && !flush && !mispredict;
  assign wr_en       = issue && issue_wb && (issue_rd != '0);

  // x0 is never written, so its entry is a constant zero rather than a counter.
  assign pend[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_pend
      hazard_sb_counter #(.CW(CW)) u_entry (
        .clk      (clk),
        .reset    (reset),
        .load     (wr_en && (issue_rd == REG_ID_WIDTH'(gi))),
        .load_val (lat_clamped),
        .count    (pend[gi])
      );
    end
  endgenerate

  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_used[i] && (pend[src_id[i*REG_ID_WIDTH +: REG_ID_WIDTH]] != '0)) begin
        raw = 1'b1;
      end
    end
  end

  // Keeps an older long-latency write from landing after a younger short one.
  assign waw = issue_wb && (issue_rd != '0) && (pend[issue_rd] > issue_lat);

  assign correct_pc  = branch_taken_ex ? target_ex : pc_ex + DATA_WIDTH'(seq_pc_inc());
  assign mispredict  = !reset && branch_valid_ex && (correct_pc != pc_id);
  assign redirect_pc = mispredict ? correct_pc : '0;
  assign flush       = !reset && (mispredict || (flush_cnt_reg != '0));
  assign stall       = !reset && issue_valid && (raw || waw) && !mispredict && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt_reg <= '0;
    end else if (mispredict) begin
      flush_cnt_reg <= FCW'(FLUSH_DEPTH);
    end else if (flush_cnt_reg != '0) begin
      flush_cnt_reg <= flush_cnt_reg - FCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_events_reg      <= '0;
      mispredict_events_reg <= '0;
    end else begin
      if (stall && (stall_events_reg != '1)) begin
        stall_events_reg <= stall_events_reg + CNT_WIDTH'(1);
      end
      if (mispredict && (mispredict_events_reg != '1)) begin
        mispredict_events_reg <= mispredict_events_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_events      = stall_events_reg;
  assign mispredict_events = mispredict_events_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus random traffic checked against a queue-fed model.
module tb_hazard_scoreboard;

  localparam int DW   = 64;
  localparam int RW   = 5;
  localparam int NS   = 2;
  localparam int ML   = 4;
  localparam int FD   = 2;
  localparam int CNTW = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             issue_valid;
  logic             issue_wb;
  logic [RW-1:0]    issue_rd;
  logic [CW-1:0]    issue_lat;
  logic [NS*RW-1:0] src_id;
  logic [NS-1:0]    src_used;
  logic             branch_valid_ex;
  logic             branch_taken_ex;
  logic [DW-1:0]    target_ex;
  logic [DW-1:0]    pc_ex;
  logic [DW-1:0]    pc_id;
  logic             stall;
  logic             mispredict;
  logic [DW-1:0]    redirect_pc;
  logic             flush;
  logic [CNTW-1:0]  stall_events;
  logic [CNTW-1:0]  mispredict_events;

  hazard_scoreboard #(
    .DATA_WIDTH(DW), .REG_ID_WIDTH(RW), .NUM_SRC(NS),
    .MAX_LAT(ML), .FLUSH_DEPTH(FD), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wb(issue_wb),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .src_id(src_id), .src_used(src_used),
    .branch_valid_ex(branch_valid_ex), .branch_taken_ex(branch_taken_ex),
    .target_ex(target_ex), .pc_ex(pc_ex), .pc_id(pc_id),
    .stall(stall), .mispredict(mispredict), .redirect_pc(redirect_pc), .flush(flush),
    .stall_events(stall_events), .mispredict_events(mispredict_events)
  );

  int tests = 0;
  int fails = 0;

  int          m_pend [32];
  int          m_fc = 0;
  int          m_se = 0;
  int          m_me = 0;
  logic [63:0] exp_q [$];
  logic        obs_stall, obs_flush, obs_mis;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: predict outputs from the model, compare, advance the model at the edge.
  task automatic tick();
    logic [63:0] corr;
    logic m_mis, m_fl, m_raw, m_waw, m_stall, m_issue;
    #1;
    corr    = branch_taken_ex ? target_ex : pc_ex + 64'd4;
    m_mis   = !reset && branch_valid_ex && (corr != pc_id);
    m_fl    = !reset && (m_mis || (m_fc != 0));
    m_raw   = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (src_used[i] && (m_pend[src_id[i*RW +: RW]] != 0)) m_raw = 1'b1;
    end
    m_waw   = issue_wb && (issue_rd != 0) && (m_pend[issue_rd] > int'(issue_lat));
    m_stall = !reset && issue_valid && (m_raw || m_waw) && !m_mis && !m_fl;
    m_issue = issue_valid && !m_stall && !m_fl && !m_mis;
    exp_q.push_back(64'(m_stall));
    exp_q.push_back(64'(m_mis));
    exp_q.push_back(m_mis ? corr : 64'd0);
    exp_q.push_back(64'(m_fl));
    check_val("stall", 64'(stall), exp_q.pop_front());
    check_val("mispredict", 64'(mispredict), exp_q.pop_front());
    check_val("redirect_pc", redirect_pc, exp_q.pop_front());
    check_val("flush", 64'(flush), exp_q.pop_front());
    obs_stall = stall;
    obs_flush = flush;
    obs_mis   = mispredict;
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
      m_fc = 0; m_se = 0; m_me = 0;
    end else begin
      for (int r = 0; r < 32; r++) if (m_pend[r] > 0) m_pend[r]--;
      if (m_issue && issue_wb && (issue_rd != 0))
        m_pend[issue_rd] = (int'(issue_lat) > ML) ? ML : int'(issue_lat);
      if (m_mis) m_fc = FD;
      else if (m_fc > 0) m_fc--;
      if (m_stall && (m_se < CMAX)) m_se++;
      if (m_mis && (m_me < CMAX)) m_me++;
    end
    exp_q.push_back(64'(m_se));
    exp_q.push_back(64'(m_me));
    #1;
    check_val("stall_events", 64'(stall_events), exp_q.pop_front());
    check_val("mispredict_events", 64'(mispredict_events), exp_q.pop_front());
    $display("[TB] cyc rst=%0b iv=%0b wb=%0b rd=%0d lat=%0d src=%0h used=%0b bv=%0b -> stall=%0b mis=%0b flush=%0b se=%0d me=%0d",
             reset, issue_valid, issue_wb, issue_rd, issue_lat, src_id, src_used, branch_valid_ex,
             obs_stall, obs_mis, obs_flush, stall_events, mispredict_events);
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 0; issue_wb = 0; issue_rd = 0; issue_lat = 0;
    src_id = 0; src_used = 0;
    branch_valid_ex = 0; branch_taken_ex = 0;
    target_ex = 0; pc_ex = 0; pc_id = 64'h4;
  endtask

  task automatic drain();
    idle();
    repeat (6) tick();
  endtask

  task automatic producer(input logic [RW-1:0] rd, input logic [CW-1:0] lat);
    idle();
    issue_valid = 1; issue_wb = 1; issue_rd = rd; issue_lat = lat;
    tick();
  endtask

  task automatic reader(input logic [RW-1:0] s0, input logic [RW-1:0] s1, input logic [NS-1:0] used);
    idle();
    issue_valid = 1; src_id = {s1, s0}; src_used = used;
  endtask

  // Ticks with the current inputs until stall drops; returns the number of stalled cycles.
  task automatic count_stalls(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!obs_stall) return;
      n++;
    end
    check_val("stall_timeout", 64'(obs_stall), 64'd0);
  endtask

  task automatic count_flush(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!obs_flush) return;
      n++;
    end
    check_val("flush_timeout", 64'(obs_flush), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
    idle();
    reset = 1;
    @(negedge clk);
    // Mispredict-shaped inputs while reset is held must stay masked.
    branch_valid_ex = 1; branch_taken_ex = 1; target_ex = 64'h100; pc_id = 64'h80;
    tick();
    tick();
    check_val("reset_mispredict", 64'(obs_mis), 64'd0);
    idle();
    reset = 0;
    tick();

    producer(5'd5, 3'd1);
    reader(5'd5, 5'd0, 2'b01);
    count_stalls(n);
    check_val("load_use_stalls", 64'(n), 64'd1);
    check_val("load_use_events", 64'(stall_events), 64'd1);
    drain();

    producer(5'd7, 3'd3);
    reader(5'd0, 5'd7, 2'b10);
    count_stalls(n);
    check_val("long_lat_stalls", 64'(n), 64'd3);
    drain();

    producer(5'd7, 3'd3);
    reader(5'd7, 5'd0, 2'b00);
    count_stalls(n);
    check_val("unused_src_stalls", 64'(n), 64'd0);
    drain();

    producer(5'd0, 3'd4);
    reader(5'd0, 5'd0, 2'b11);
    count_stalls(n);
    check_val("x0_stalls", 64'(n), 64'd0);
    drain();

    producer(5'd9, 3'd7);
    reader(5'd9, 5'd0, 2'b01);
    count_stalls(n);
    check_val("clamp_stalls", 64'(n), 64'd4);
    drain();

    producer(5'd3, 3'd3);
    idle();
    issue_valid = 1; issue_wb = 1; issue_rd = 5'd3; issue_lat = 3'd0;
    count_stalls(n);
    check_val("waw_stalls", 64'(n), 64'd3);
    drain();

    // Taken branch to 0x100 while ID holds 0x80, with a RAW hazard present.
    producer(5'd6, 3'd3);
    reader(5'd6, 5'd0, 2'b01);
    branch_valid_ex = 1; branch_taken_ex = 1; target_ex = 64'h100; pc_id = 64'h80;
    tick();
    check_val("mp_flag", 64'(obs_mis), 64'd1);
    check_val("mp_stall_suppressed", 64'(obs_stall), 64'd0);
    branch_valid_ex = 0;
    count_flush(n);
    check_val("mp_flush_cycles", 64'(n + 1), 64'(1 + FD));
    drain();

    idle();
    branch_valid_ex = 1; branch_taken_ex = 0; pc_ex = 64'hFFFF_FFFF_FFFF_FFFC; pc_id = 64'h0;
    target_ex = 64'h1234;
    tick();
    check_val("wrap_no_mispredict", 64'(obs_mis), 64'd0);
    drain();

    // Second mispredict arrives when one flush cycle remains.
    idle();
    branch_valid_ex = 1; branch_taken_ex = 1; target_ex = 64'h200; pc_id = 64'h80;
    tick();
    branch_valid_ex = 0;
    tick();
    branch_valid_ex = 1;
    tick();
    branch_valid_ex = 0;
    count_flush(n);
    check_val("flush_reload_cycles", 64'(n), 64'(FD));
    drain();

    branch_valid_ex = 1; branch_taken_ex = 1; target_ex = 64'h200; pc_id = 64'h80;
    tick();
    branch_valid_ex = 0;
    reset = 1;
    tick();
    reset = 0;
    tick();
    check_val("reset_mid_flush", 64'(obs_flush), 64'd0);

    producer(5'd8, 3'd4);
    reader(5'd8, 5'd0, 2'b01);
    tick();
    reset = 1;
    tick();
    reset = 0;
    tick();
    check_val("reset_mid_stall", 64'(obs_stall), 64'd0);
    drain();

    idle();
    branch_valid_ex = 1; branch_taken_ex = 1; target_ex = 64'h300; pc_id = 64'h0;
    repeat (CMAX + 5) tick();
    check_val("mispredict_saturate", 64'(mispredict_events), 64'(CMAX));
    drain();
    for (int k = 0; k < 5; k++) begin
      producer(5'd10, 3'd4);
      reader(5'd10, 5'd0, 2'b01);
      count_stalls(n);
    end
    check_val("stall_saturate", 64'(stall_events), 64'(CMAX));

    for (int k = 0; k < 300; k++) begin
      reset           = ($urandom_range(0, 49) == 0);
      issue_valid     = 1'($urandom_range(0, 1));
      issue_wb        = 1'($urandom_range(0, 1));
      issue_rd        = RW'($urandom_range(0, 3));
      issue_lat       = CW'($urandom_range(0, 7));
      src_id          = {RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3))};
      src_used        = NS'($urandom_range(0, 3));
      branch_valid_ex = ($urandom_range(0, 7) == 0);
      branch_taken_ex = 1'($urandom_range(0, 1));
      target_ex       = $urandom_range(0, 1) ? 64'h40 : 64'h44;
      pc_ex           = 64'h40;
      pc_id           = $urandom_range(0, 1) ? 64'h40 : 64'h44;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
